// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM states, GF(2^8) arithmetic, S-boxes, round
// constants, byte/word packing and the on-the-fly key-schedule steps.
package aes_pkg;

  localparam int NR = 10;
  localparam int NK = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    KEYX = 3'd2,
    DECR = 3'd3,
    DONE = 3'd4
  } state_t;

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = gf_mul2(x);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 (product of a^2, a^4, ... a^128); 0 maps to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] sq;
    sq = gf_mul(a, a);
    r  = sq;
    for (int i = 1; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] x;
    x = gf_inv(b);
    return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return gf_inv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Byte idx = 4*column + row; byte 0 (S0,0) sits in [127:120].
  function automatic logic [7:0] get_byte(input logic [127:0] blk, input int idx);
    return blk[127-8*idx -: 8];
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] fwd_step(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = rk[127:96] ^ sub_rot_word(rk[31:0]) ^ {rc, 24'h0};
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] inv_step(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = rk[31:0] ^ rk[63:32];
    w2 = rk[63:32] ^ rk[95:64];
    w1 = rk[95:64] ^ rk[127:96];
    w0 = rk[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless last_round is set.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] st,
  input  logic [127:0] rk,
  input  logic         last_round,
  output logic [127:0] out
);

  logic [127:0] ark;
  logic [127:0] mixed;

  // Row r rotates right by r columns, then inverse S-box and key add.
  always_comb begin
    ark = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        ark[127-8*(4*c+r) -: 8] = inv_sbox(get_byte(st, 4*((c - r + 4) % 4) + r))
                                  ^ get_byte(rk, 4*c + r);
      end
    end
  end

  // Column-wise multiply by the inverse MixColumns matrix {0e,0b,0d,09}.
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = get_byte(ark, 4*c);
      a1 = get_byte(ark, 4*c + 1);
      a2 = get_byte(ark, 4*c + 2);
      a3 = get_byte(ark, 4*c + 3);
      mixed[127-32*c -: 32] = {
        gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
        gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
        gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
        gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    end
  end

  // Final round skips InvMixColumns.
  always_comb begin
    out = last_round ? ark : mixed;
  end

endmodule

// File: rtl/aes_inv_core.sv
// Iterative AES-128 decryptor, one round per clock. Round keys are rebuilt on
// the fly: forward to round 10 first, then walked backwards during decryption.
// Handshake: while ce is high, key and cyphertext are captured every cycle and
// any running job is dropped; after ce falls, done rises on the 21st edge and
// plaintext/done hold until the next ce or reset.
module aes_inv_core
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         ce,
  input  logic [127:0] key,
  input  logic [127:0] cyphertext,
  output logic         done,
  output logic [127:0] plaintext
);

  localparam logic [3:0] KEY_DONE_CNT = 4'(NR + 1);

  state_t       state_q, state_d;
  logic [127:0] st_q, rk_q, pt_q;
  logic [3:0]   cnt_q;
  logic         done_q;
  logic [127:0] round_out;

  aes_inv_round u_round (
    .st         (st_q),
    .rk         (rk_q),
    .last_round (cnt_q == 4'd0),
    .out        (round_out)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; ce overrides every state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = IDLE;
      LOAD:    state_d = KEYX;
      KEYX:    if (cnt_q == KEY_DONE_CNT) state_d = DECR;
      DECR:    if (cnt_q == 4'd0) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (ce) state_d = LOAD;
  end

  // Datapath. The edge that leaves LOAD already performs the first forward key
  // step, so the round-10 key is ready after edge 10 and done lands on edge 21.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= '0;
      rk_q   <= '0;
      pt_q   <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (ce) begin
      st_q   <= cyphertext;
      rk_q   <= key;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          rk_q  <= fwd_step(rk_q, rcon(4'd1));
          cnt_q <= 4'd2;
        end
        KEYX: begin
          if (cnt_q == KEY_DONE_CNT) begin
            st_q  <= st_q ^ rk_q;
            rk_q  <= inv_step(rk_q, rcon(4'(NR)));
            cnt_q <= 4'(NR - 1);
          end else begin
            rk_q  <= fwd_step(rk_q, rcon(cnt_q));
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DECR: begin
          if (cnt_q == 4'd0) begin
            pt_q   <= round_out;
            done_q <= 1'b1;
          end else begin
            st_q  <= round_out;
            rk_q  <= inv_step(rk_q, rcon(cnt_q));
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign done      = done_q;
  assign plaintext = pt_q;

endmodule
